// File: rtl/axis_2_fifo_adapter.sv
// axis_2_fifo_adapter: AXI-Stream sink that forwards beats into a FIFO write port.
// Beats pass through a two-entry skid buffer (main + skid). o_axis_tready is
// registered and drops whenever the skid entry is occupied. The FIFO write
// strobe is combinational from the main entry and i_fifo_not_full.
// Optional feature: define AXIS_2_FIFO_PKT_CNT_EN to build the packet counter
// that counts FIFO writes carrying tlast. Without it, o_pkt_count is tied to 0.
module axis_2_fifo_adapter #(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned PKT_CNT_WIDTH   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
  input  logic                       i_axis_tvalid,
  output logic                       o_axis_tready,
  input  logic                       i_axis_tlast,
  input  logic                       i_axis_tuser,
  output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
  output logic                       o_fifo_w_stb,
  input  logic                       i_fifo_not_full,
  output logic [PKT_CNT_WIDTH-1:0]   o_pkt_count
);

  localparam int unsigned DW = AXIS_DATA_WIDTH;

  // Buffer state
  logic [DW-1:0] main_data_q, main_data_d;
  logic          main_last_q, main_last_d;
  logic          main_valid_q, main_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          skid_last_q, skid_last_d;
  logic          skid_valid_q, skid_valid_d;
  logic          tready_q, tready_d;

  logic          accept;
  logic          main_free;
  logic          unused_ok;

  // Handshake terms
  assign accept       = i_axis_tvalid & tready_q;
  assign o_fifo_w_stb = main_valid_q & i_fifo_not_full;
  assign main_free    = ~main_valid_q | o_fifo_w_stb;

  // FIFO side is fed straight from the main entry, zero-extended
  assign o_fifo_data   = FIFO_DATA_WIDTH'(main_data_q);
  assign o_axis_tready = tready_q;

  // tuser is ignored; last only feeds the optional counter
  assign unused_ok = ^{i_axis_tuser, main_last_q};

  // Next-state for main/skid entries and the ready flag
  always_comb begin
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;

    if (main_free) begin
      if (skid_valid_q) begin
        // Oldest beat lives in skid, so it refills main first
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = i_axis_tdata;
        main_last_d  = i_axis_tlast;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // New beat parks in skid whenever main cannot take it this cycle
    if (accept && !(main_free && !skid_valid_q)) begin
      skid_data_d  = i_axis_tdata;
      skid_last_d  = i_axis_tlast;
      skid_valid_d = 1'b1;
    end

    tready_d = ~skid_valid_d;
  end

  // Buffer and ready registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
      tready_q     <= tready_d;
    end
  end

`ifdef AXIS_2_FIFO_PKT_CNT_EN
  logic [PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  // Count packets as their last beat is written to the FIFO
  always_comb begin
    pkt_count_d = pkt_count_q;
    if (o_fifo_w_stb && main_last_q) begin
      pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
    end
  end

  // Packet counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign o_pkt_count = pkt_count_q;
`else
  assign o_pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_2_fifo_adapter.sv
// Testbench for axis_2_fifo_adapter (AXIS 32 -> FIFO 40, 4-bit packet counter).
// Accepted beats are pushed to a scoreboard queue; every FIFO write pops and compares.
module tb_axis_2_fifo_adapter;

  localparam int unsigned AW = 32;
  localparam int unsigned FW = 40;
  localparam int unsigned CW = 4;
`ifdef AXIS_2_FIFO_PKT_CNT_EN
  localparam bit PKT_EN = 1'b1;
`else
  localparam bit PKT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tlast = 1'b0;
  logic          tuser = 1'b0;
  logic [FW-1:0] fifo_data;
  logic          w_stb;
  logic          not_full = 1'b0;
  logic [CW-1:0] pkt_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW:0]   sb[$];
  logic [CW-1:0] exp_pkt = '0;

  axis_2_fifo_adapter #(
    .AXIS_DATA_WIDTH(AW),
    .FIFO_DATA_WIDTH(FW),
    .PKT_CNT_WIDTH  (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_axis_tdata   (tdata),
    .i_axis_tvalid  (tvalid),
    .o_axis_tready  (tready),
    .i_axis_tlast   (tlast),
    .i_axis_tuser   (tuser),
    .o_fifo_data    (fifo_data),
    .o_fifo_w_stb   (w_stb),
    .i_fifo_not_full(not_full),
    .o_pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [AW:0]   e;
    logic [CW-1:0] exp_cnt;
    if (rst) begin
      sb.delete();
      exp_pkt = '0;
    end else begin
      exp_cnt = PKT_EN ? exp_pkt : '0;
      n_cmp++;
      if (pkt_count !== exp_cnt) begin
        n_err++;
        $display("FAIL pkt_count: got %0d expected %0d at %0t", pkt_count, exp_cnt, $time);
      end
      if (w_stb === 1'b1) begin
        n_cmp++;
        if (not_full !== 1'b1) begin
          n_err++;
          $display("FAIL w_stb_while_full: got w_stb=1 expected 0 at %0t", $time);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got data %h expected no write at %0t", fifo_data, $time);
        end else begin
          e = sb.pop_front();
          if (fifo_data !== {8'h00, e[AW-1:0]}) begin
            n_err++;
            $display("FAIL fifo_data: got %h expected %h at %0t", fifo_data, {8'h00, e[AW-1:0]}, $time);
          end
          if (e[AW]) exp_pkt = exp_pkt + CW'(1);
        end
      end
      if (tvalid === 1'b1 && tready === 1'b1) sb.push_back({tlast, tdata});
    end
  end

  // Hold a beat on the bus until the adapter takes it (bounded)
  task automatic send_beat(input logic [AW-1:0] d, input logic l);
    bit done;
    done   = 1'b0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (tready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got tready=0 for 200 cycles expected accept, data %h", d);
    end
  endtask

  // Let the FIFO drain the buffer (bounded)
  task automatic drain();
    not_full = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    not_full = 1'b1;
    tvalid   = 1'b1;
    tdata    = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 4;
    if (tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b expected 0", tready); end
    if (w_stb !== 1'b0) begin n_err++; $display("FAIL rst_w_stb: got %b expected 0", w_stb); end
    if (pkt_count !== '0) begin n_err++; $display("FAIL rst_pkt_count: got %0d expected 0", pkt_count); end
    if (fifo_data !== '0) begin n_err++; $display("FAIL rst_fifo_data: got %h expected 0", fifo_data); end
    @(posedge clk); #1;
    tvalid = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tready !== 1'b0) begin n_err++; $display("FAIL rel_tready_early: got %b expected 0", tready); end
    @(posedge clk); #1;
    n_cmp++;
    if (tready !== 1'b1) begin n_err++; $display("FAIL rel_tready: got %b expected 1", tready); end
  endtask

  task automatic test_stream();
    not_full = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tvalid = 1'b1;
      tdata  = AW'(k + 1);
      tlast  = (k == 7);
      @(negedge clk);
      n_cmp += 2;
      if (tready !== 1'b1) begin n_err++; $display("FAIL stream_tready: got %b expected 1 beat %0d", tready, k); end
      if (w_stb !== (k > 0)) begin n_err++; $display("FAIL stream_w_stb: got %b expected %b beat %0d", w_stb, k > 0, k); end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (w_stb !== 1'b1) begin n_err++; $display("FAIL stream_last_w_stb: got %b expected 1", w_stb); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp += 2;
    if (w_stb !== 1'b0) begin n_err++; $display("FAIL stream_idle_w_stb: got %b expected 0", w_stb); end
    if (pkt_count !== (PKT_EN ? CW'(1) : CW'(0))) begin
      n_err++; $display("FAIL stream_pkt_count: got %0d expected %0d", pkt_count, PKT_EN ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    not_full = 1'b0;
    send_beat(32'hA, 1'b0);
    tvalid = 1'b1;
    tdata  = 32'hB;
    tlast  = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (tready !== 1'b1) begin n_err++; $display("FAIL bp_tready_b: got %b expected 1", tready); end
    if (w_stb !== 1'b0) begin n_err++; $display("FAIL bp_w_stb: got %b expected 0", w_stb); end
    if (fifo_data !== 40'hA) begin n_err++; $display("FAIL bp_main: got %h expected a", fifo_data); end
    @(posedge clk); #1;
    tdata = 32'hC;
    tlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp += 2;
      if (tready !== 1'b0) begin n_err++; $display("FAIL bp_tready_c: got %b expected 0 cycle %0d", tready, i); end
      if (fifo_data !== 40'hA) begin n_err++; $display("FAIL bp_hold: got %h expected a cycle %0d", fifo_data, i); end
      @(posedge clk); #1;
    end
    not_full = 1'b1;
    send_beat(32'hC, 1'b1);
    drain();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_toggle();
    bit tog_run;
    tog_run = 1'b1;
    fork
      begin
        while (tog_run) begin
          @(posedge clk); #1;
          not_full = ~not_full;
        end
      end
      begin
        for (int k = 0; k < 100; k++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send_beat($urandom, 1'($urandom_range(0, 1)));
        end
        tog_run = 1'b0;
      end
    join
    drain();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL toggle_drain: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    not_full = 1'b0;
    send_beat(32'hDEAD_0001, 1'b1);
    send_beat(32'hDEAD_0002, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (tready !== 1'b0) begin n_err++; $display("FAIL mid_full_tready: got %b expected 0", tready); end
    @(posedge clk); #1;
    rst      = 1'b1;
    not_full = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (tready !== 1'b0) begin n_err++; $display("FAIL mid_rst_tready: got %b expected 0", tready); end
    if (w_stb !== 1'b0) begin n_err++; $display("FAIL mid_rst_w_stb: got %b expected 0", w_stb); end
    if (fifo_data !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h expected 0", fifo_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (tready !== 1'b1) begin n_err++; $display("FAIL mid_rel_tready: got %b expected 1", tready); end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    pulse_reset();
    not_full = 1'b1;
    for (int k = 0; k < 17; k++) send_beat(AW'(32'h100 + k), 1'b1);
    drain();
    n_cmp++;
    if (pkt_count !== (PKT_EN ? CW'(1) : CW'(0))) begin
      n_err++; $display("FAIL wrap_pkt_count: got %0d expected %0d", pkt_count, PKT_EN ? 1 : 0);
    end
  endtask

  task automatic test_width();
    not_full = 1'b0;
    send_beat(32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (fifo_data !== 40'h00FF_FFFF_FF) begin
      n_err++; $display("FAIL width_ext: got %h expected 00ffffffff", fifo_data);
    end
    @(posedge clk); #1;
    drain();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL width_drain: got %0d pending expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_wrap();
    test_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_2_fifo_adapter.md
AXIS_2_FIFO_ADAPTER -- requirements
Module: axis_2_fifo_adapter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, width of the AXI-Stream data bus.
REQ-002 SHALL have parameter FIFO_DATA_WIDTH, default AXIS_DATA_WIDTH, width of the FIFO write word; legal only if >= AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter PKT_CNT_WIDTH, default 16, width of the packet counter.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_axis_tdata  input  AXIS_DATA_WIDTH  stream data.
REQ-007 SHALL have port i_axis_tvalid  input  1  stream beat valid.
REQ-008 SHALL have port o_axis_tready  output  1  adapter can accept a beat; driven from a register.
REQ-009 SHALL have port i_axis_tlast  input  1  last beat of a packet.
REQ-010 SHALL have port i_axis_tuser  input  1  ignored.
REQ-011 SHALL have port o_fifo_data  output  FIFO_DATA_WIDTH  FIFO write word.
REQ-012 SHALL have port o_fifo_w_stb  output  1  single-cycle FIFO write strobe.
REQ-013 SHALL have port i_fifo_not_full  input  1  FIFO can take a word this cycle.
REQ-014 SHALL have port o_pkt_count  output  PKT_CNT_WIDTH  completed packets written to the FIFO.

Function
REQ-015 SHALL treat a beat as accepted in a cycle where i_axis_tvalid and o_axis_tready are both 1.
REQ-016 SHALL hold beats in a two-entry skid buffer: main register (data, last, valid) and skid register (data, last, valid).
REQ-017 SHALL drive o_fifo_data from the main register, with the data zero-extended to FIFO_DATA_WIDTH.
REQ-018 SHALL drive o_fifo_w_stb = main_valid AND i_fifo_not_full, combinationally.
REQ-019 SHALL treat main as "free" in a cycle when main_valid is 0 or o_fifo_w_stb is 1.
REQ-020 SHALL load an accepted beat into main when main is free, and into skid otherwise.
REQ-021 SHALL, when skid_valid is 1 and main is free, move skid into main and clear skid_valid.
REQ-022 SHALL register o_axis_tready as NOT(next skid_valid), so it is low for every cycle skid holds a beat.
REQ-023 SHALL write an accepted beat to the FIFO no earlier than the cycle after acceptance (minimum latency 1 cycle).
REQ-024 SHALL sustain 1 beat per cycle while i_fifo_not_full stays 1.
REQ-025 SHALL preserve beat order exactly, with no loss and no duplication, under any combination of tvalid and i_fifo_not_full toggling.
REQ-026 SHALL hold o_fifo_data and main_valid stable while i_fifo_not_full is 0.
REQ-027 SHALL NOT change o_pkt_count or data flow in response to i_axis_tuser.

Reset
REQ-028 SHALL, while i_rst is 1, force main_valid=0, skid_valid=0, both data registers=0, o_axis_tready=0, o_fifo_w_stb=0 and o_pkt_count=0.
REQ-029 SHALL drive o_axis_tready to 1 on the first rising edge after i_rst deasserts.
REQ-030 SHALL discard any beats held in the buffer when i_rst asserts mid-stream, with no FIFO write from them afterwards.

Configuration
REQ-031 SHALL, when macro AXIS_2_FIFO_PKT_CNT_EN is defined, increment o_pkt_count by 1 on each FIFO write whose main last bit is 1, wrapping modulo 2^PKT_CNT_WIDTH.
REQ-032 SHALL, when AXIS_2_FIFO_PKT_CNT_EN is undefined, tie o_pkt_count to 0 and build no counter logic.

Verification
REQ-033 SHALL cover streaming: 8 beats 0x1..0x8 back-to-back, tlast on 0x8, not_full=1 -> 8 consecutive w_stb starting 1 cycle after the first accept, data 0x1..0x8, tready stays 1, o_pkt_count=1 (macro on).
REQ-034 SHALL cover backpressure: not_full=0 from beat 0xA onward while source streams 0xA,0xB,0xC -> main holds 0xA, skid holds 0xB, tready drops to 0 before 0xC is accepted; after not_full=1, writes 0xA,0xB,0xC in order.
REQ-035 SHALL cover a toggling FIFO: not_full toggles every cycle, 100 random beats -> FIFO contents equal the input sequence, with no w_stb when not_full=0.
REQ-036 SHALL cover reset mid-stream: i_rst pulsed with both buffer entries valid -> tready=0 and w_stb=0 during reset, no stale writes after release, tready=1 one edge after release.
REQ-037 SHALL cover counter wrap: PKT_CNT_WIDTH=4, 17 single-beat packets with tlast=1 -> o_pkt_count=1 (macro on) and 0 (macro off).
REQ-038 SHALL cover width extension: FIFO_DATA_WIDTH=40, AXIS_DATA_WIDTH=32, tdata=0xFFFFFFFF -> o_fifo_data=0x00FFFFFFFF.
